// File: rtl/lii_pkt_fifo_pkg.sv
// Shared LII beat-format defaults, beat-width helper and the oversize-release state encoding.
// Pure definitions: no latency, no flow control.
package lii_pkt_fifo_pkg;

    localparam int LII_DW_DEF     = 256;
    localparam int LII_SRC_W_DEF  = 8;
    localparam int LII_DST_W_DEF  = 8;
    localparam int LII_TYPE_W_DEF = 2;

    typedef enum logic {
        OVS_IDLE    = 1'b0,
        OVS_RELEASE = 1'b1
    } ovs_state_t;

    // Stored beat width, packed as {data, keep, strb, last, src, dst, type}.
    function automatic int lii_beat_w(input int dw, input int src_w, input int dst_w, input int type_w);
        return dw + 2 * (dw / 8) + 1 + src_w + dst_w + type_w;
    endfunction

endpackage

// File: rtl/lii_pkt_fifo_ram.sv
// Beat storage: DEPTH x W, one synchronous write port, one combinational read port.
// Latency: a write at edge N is readable after edge N. No flow control; the caller owns the pointers.
module lii_pkt_fifo_ram #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lii_pkt_fifo.sv
// LII beat FIFO, cut-through or store-and-forward on s_last, with level/pkt_count/almost_full status.
// Latency: 1 cycle write-to-read; in packet mode the first beat is valid the cycle after its last beat lands.
// Backpressure: s_ready = not full (no same-cycle bypass); m_* held stable while m_valid & ~m_ready.
module lii_pkt_fifo
    import lii_pkt_fifo_pkg::*;
#(
    parameter int DW           = LII_DW_DEF,
    parameter int SRC_W        = LII_SRC_W_DEF,
    parameter int DST_W        = LII_DST_W_DEF,
    parameter int TYPE_W       = LII_TYPE_W_DEF,
    parameter int DEPTH        = 16,
    parameter int PKT_MODE     = 1,
    parameter int AFULL_THRESH = DEPTH - 4,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DW-1:0]     s_data,
    input  logic [DW/8-1:0]   s_keep,
    input  logic [DW/8-1:0]   s_strb,
    input  logic              s_last,
    input  logic [SRC_W-1:0]  s_src,
    input  logic [DST_W-1:0]  s_dst,
    input  logic [TYPE_W-1:0] s_type,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DW-1:0]     m_data,
    output logic [DW/8-1:0]   m_keep,
    output logic [DW/8-1:0]   m_strb,
    output logic              m_last,
    output logic [SRC_W-1:0]  m_src,
    output logic [DST_W-1:0]  m_dst,
    output logic [TYPE_W-1:0] m_type,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [AW:0]       level,
    output logic [AW:0]       pkt_count,
    output logic              almost_full
);

    typedef struct packed {
        logic [DW-1:0]     data;
        logic [DW/8-1:0]   keep;
        logic [DW/8-1:0]   strb;
        logic              last;
        logic [SRC_W-1:0]  src;
        logic [DST_W-1:0]  dst;
        logic [TYPE_W-1:0] typ;
    } beat_t;

    localparam int          TW      = lii_beat_w(DW, SRC_W, DST_W, TYPE_W);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("lii_pkt_fifo: DEPTH must be a power of 2 and >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
        $error("lii_pkt_fifo: AFULL_THRESH must be within 1..DEPTH");
    end

    logic [AW:0] wr_ptr, rd_ptr, pkt_cnt_q;
    ovs_state_t  ovs_q, ovs_d;
    logic        empty, full, push, pop, oversize;
    beat_t       wr_beat, rd_beat;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign oversize = (ovs_q == OVS_RELEASE);

    assign s_ready  = ~full;
    assign m_valid  = (PKT_MODE != 0) ? (~empty & ((pkt_cnt_q != '0) | oversize)) : ~empty;
    assign push     = s_valid & s_ready;
    assign pop      = m_valid & m_ready;

    assign wr_beat = '{data: s_data, keep: s_keep, strb: s_strb, last: s_last,
                       src: s_src, dst: s_dst, typ: s_type};

    lii_pkt_fifo_ram #(
        .W     (TW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_beat),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_beat)
    );

    assign m_data = rd_beat.data;
    assign m_keep = rd_beat.keep;
    assign m_strb = rd_beat.strb;
    assign m_last = rd_beat.last;
    assign m_src  = rd_beat.src;
    assign m_dst  = rd_beat.dst;
    assign m_type = rd_beat.typ;

    // A full FIFO holding no complete packet can never drain by itself: stream it out until its last beat.
    always_comb begin
        ovs_d = ovs_q;
        case (ovs_q)
            OVS_IDLE:    if (PKT_MODE != 0 && full && pkt_cnt_q == '0) ovs_d = OVS_RELEASE;
            OVS_RELEASE: if (pop && rd_beat.last) ovs_d = OVS_IDLE;
            default:     ovs_d = OVS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pkt_cnt_q <= '0;
            ovs_q     <= OVS_IDLE;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if ((push && s_last) && !(pop && rd_beat.last)) begin
                pkt_cnt_q <= pkt_cnt_q + PTR_ONE;
            end else if (!(push && s_last) && (pop && rd_beat.last)) begin
                pkt_cnt_q <= pkt_cnt_q - PTR_ONE;
            end
            ovs_q <= ovs_d;
        end
    end

    assign level       = wr_ptr - rd_ptr;
    assign pkt_count   = pkt_cnt_q;
    assign almost_full = (level >= (AW + 1)'(AFULL_THRESH));

endmodule

// File: tb/tb_lii_pkt_fifo.sv
// Bench for lii_pkt_fifo: a cut-through and a packet-mode instance (DEPTH=4) checked by
// a vector table, directed packet sequences and a per-cycle queue scoreboard.
module tb_lii_pkt_fifo;

    localparam int DW = 32, SRC_W = 8, DST_W = 8, TYPE_W = 2, DEPTH = 4, AW = 2, THR = 3;

    typedef struct packed {
        logic [DW-1:0]     data;
        logic [DW/8-1:0]   keep;
        logic [DW/8-1:0]   strb;
        logic              last;
        logic [SRC_W-1:0]  src;
        logic [DST_W-1:0]  dst;
        logic [TYPE_W-1:0] typ;
    } beat_t;

    typedef struct {
        bit          vld;
        bit          last;
        bit          rdy;
        logic [31:0] dat;
        int          lvl;
        bit          srdy;
        bit          af;
        bit          mv;
        logic [31:0] mdat;
        int          pkt;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic [DW-1:0]     s_data;
    logic [DW/8-1:0]   s_keep, s_strb;
    logic              s_last;
    logic [SRC_W-1:0]  s_src;
    logic [DST_W-1:0]  s_dst;
    logic [TYPE_W-1:0] s_type;
    logic              s_valid [2];
    logic              s_ready [2];
    logic              m_ready [2];
    logic              m_valid [2];
    logic [DW-1:0]     m_data  [2];
    logic [DW/8-1:0]   m_keep  [2];
    logic [DW/8-1:0]   m_strb  [2];
    logic              m_last  [2];
    logic [SRC_W-1:0]  m_src   [2];
    logic [DST_W-1:0]  m_dst   [2];
    logic [TYPE_W-1:0] m_type  [2];
    logic [AW:0]       level   [2];
    logic [AW:0]       pkt_count [2];
    logic              almost_full [2];

    int    n_chk = 0, n_pass = 0;
    beat_t sb_q [2][$];
    int    sb_lasts [2];
    int    pops [2];
    bit    saw_full [2];
    bit    saw_ovs;
    vec_t  vt [10];

    always #5 clk = ~clk;

    lii_pkt_fifo #(.DW(DW), .SRC_W(SRC_W), .DST_W(DST_W), .TYPE_W(TYPE_W),
                   .DEPTH(DEPTH), .PKT_MODE(0), .AFULL_THRESH(THR)) u_cut (
        .clk(clk), .rstn(rstn),
        .s_data(s_data), .s_keep(s_keep), .s_strb(s_strb), .s_last(s_last),
        .s_src(s_src), .s_dst(s_dst), .s_type(s_type), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .m_data(m_data[0]), .m_keep(m_keep[0]), .m_strb(m_strb[0]), .m_last(m_last[0]),
        .m_src(m_src[0]), .m_dst(m_dst[0]), .m_type(m_type[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
        .level(level[0]), .pkt_count(pkt_count[0]), .almost_full(almost_full[0])
    );

    lii_pkt_fifo #(.DW(DW), .SRC_W(SRC_W), .DST_W(DST_W), .TYPE_W(TYPE_W),
                   .DEPTH(DEPTH), .PKT_MODE(1), .AFULL_THRESH(THR)) u_sf (
        .clk(clk), .rstn(rstn),
        .s_data(s_data), .s_keep(s_keep), .s_strb(s_strb), .s_last(s_last),
        .s_src(s_src), .s_dst(s_dst), .s_type(s_type), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .m_data(m_data[1]), .m_keep(m_keep[1]), .m_strb(m_strb[1]), .m_last(m_last[1]),
        .m_src(m_src[1]), .m_dst(m_dst[1]), .m_type(m_type[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
        .level(level[1]), .pkt_count(pkt_count[1]), .almost_full(almost_full[1])
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: retire before enqueue, since a beat can never leave in the cycle it arrives.
    task automatic mon(input int i);
        beat_t inb, outb, expb;
        chk("model_level", 64'(level[i]), 64'(sb_q[i].size()));
        chk("model_pkt_count", 64'(pkt_count[i]), 64'(sb_lasts[i]));
        if (sb_q[i].size() == 0) chk("valid_on_empty", 64'(m_valid[i]), 64'(0));
        else if (i == 0 || sb_lasts[i] > 0) chk("valid_with_data", 64'(m_valid[i]), 64'(1));
        if (level[i] == 3'(DEPTH)) saw_full[i] = 1'b1;
        if (m_valid[i] && m_ready[i] && sb_q[i].size() != 0) begin
            outb = '{data: m_data[i], keep: m_keep[i], strb: m_strb[i], last: m_last[i],
                     src: m_src[i], dst: m_dst[i], typ: m_type[i]};
            expb = sb_q[i].pop_front();
            chk("beat", 64'(outb), 64'(expb));
            pops[i]++;
            if (expb.last) sb_lasts[i]--;
        end
        if (s_valid[i] && s_ready[i]) begin
            inb = '{data: s_data, keep: s_keep, strb: s_strb, last: s_last,
                    src: s_src, dst: s_dst, typ: s_type};
            sb_q[i].push_back(inb);
            if (s_last) sb_lasts[i]++;
        end
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                sb_q[i].delete();
                sb_lasts[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) mon(i);
            if (u_sf.oversize) saw_ovs = 1'b1;
        end
    end

    task automatic send(input int i, input logic [31:0] d, input bit last);
        int t = 0;
        bit acc;
        s_valid[i] = 1'b1;
        s_data     = d;
        s_last     = last;
        do begin
            acc = s_ready[i];
            step();
            t++;
        end while (!acc && t < 50);
        s_valid[i] = 1'b0;
        if (!acc) chk("send_accept_timeout", 64'(acc), 64'(1));
    endtask

    task automatic drain(input int i);
        int t = 0;
        m_ready[i] = 1'b1;
        while (level[i] != '0 && t < 200) begin
            step();
            t++;
        end
        m_ready[i] = 1'b0;
        chk("drain_empty", 64'(level[i]), 64'(0));
    endtask

    task automatic rand_run(input int i, input int nbeats);
        int sent = 0, cyc = 0;
        bit acc;
        while (sent < nbeats && cyc < 40 * nbeats) begin
            s_valid[i] = ($urandom_range(0, 99) < 60);
            s_data     = $urandom;
            s_keep     = 4'($urandom);
            s_strb     = 4'($urandom);
            s_src      = 8'($urandom);
            s_dst      = 8'($urandom);
            s_type     = 2'($urandom);
            s_last     = (sent == nbeats - 1) || ($urandom_range(0, 4) == 0);
            m_ready[i] = ($urandom_range(0, 99) < 60);
            acc        = s_valid[i] && s_ready[i];
            step();
            cyc++;
            if (acc) sent++;
        end
        s_valid[i] = 1'b0;
        chk("rand_all_sent", 64'(sent), 64'(nbeats));
        drain(i);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int p0;
        vt[0] = '{1, 0, 0, 32'hA000_0000, 1, 1, 0, 1, 32'hA000_0000, 0};
        vt[1] = '{1, 0, 0, 32'hA000_0001, 2, 1, 0, 1, 32'hA000_0000, 0};
        vt[2] = '{1, 0, 0, 32'hA000_0002, 3, 1, 1, 1, 32'hA000_0000, 0};
        vt[3] = '{1, 1, 0, 32'hA000_0003, 4, 0, 1, 1, 32'hA000_0000, 1};
        vt[4] = '{1, 1, 0, 32'hA000_0004, 4, 0, 1, 1, 32'hA000_0000, 1};
        vt[5] = '{0, 0, 1, 32'hA000_0000, 3, 1, 1, 1, 32'hA000_0001, 1};
        vt[6] = '{0, 0, 1, 32'hA000_0000, 2, 1, 0, 1, 32'hA000_0002, 1};
        vt[7] = '{1, 1, 1, 32'hA000_0004, 2, 1, 0, 1, 32'hA000_0003, 2};
        vt[8] = '{0, 0, 1, 32'hA000_0000, 1, 1, 0, 1, 32'hA000_0004, 1};
        vt[9] = '{0, 0, 1, 32'hA000_0000, 0, 1, 0, 0, 32'hA000_0000, 0};

        s_valid = '{1'b0, 1'b0};
        m_ready = '{1'b0, 1'b0};
        s_data = '0; s_keep = 4'hF; s_strb = 4'h5; s_last = 1'b0;
        s_src = 8'h12; s_dst = 8'h34; s_type = 2'd1;
        #1 rstn = 1'b0;

        // Reset, with beats offered that must be discarded.
        s_valid = '{1'b1, 1'b1};
        s_last  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_m_valid", 64'(m_valid[i]), 64'(0));
            chk("rst_s_ready", 64'(s_ready[i]), 64'(1));
            chk("rst_level", 64'(level[i]), 64'(0));
            chk("rst_pkt_count", 64'(pkt_count[i]), 64'(0));
            chk("rst_almost_full", 64'(almost_full[i]), 64'(0));
        end
        s_valid = '{1'b0, 1'b0};
        s_last  = 1'b0;
        rstn    = 1'b1;
        step();
        chk("post_rst_level0", 64'(level[0]), 64'(0));
        chk("post_rst_level1", 64'(level[1]), 64'(0));

        // Cut-through vector table: fill to full, refused beat, pops, push+pop, drain.
        for (int k = 0; k < 10; k++) begin
            s_valid[0] = vt[k].vld;
            s_last     = vt[k].last;
            s_data     = vt[k].dat;
            m_ready[0] = vt[k].rdy;
            step();
            chk("vec_level", 64'(level[0]), 64'(vt[k].lvl));
            chk("vec_s_ready", 64'(s_ready[0]), 64'(vt[k].srdy));
            chk("vec_almost_full", 64'(almost_full[0]), 64'(vt[k].af));
            chk("vec_m_valid", 64'(m_valid[0]), 64'(vt[k].mv));
            chk("vec_pkt_count", 64'(pkt_count[0]), 64'(vt[k].pkt));
            if (vt[k].mv) chk("vec_m_data", 64'(m_data[0]), 64'(vt[k].mdat));
        end
        s_valid[0] = 1'b0;
        m_ready[0] = 1'b0;

        // Packet mode: 3-beat packet held until its last beat lands.
        send(1, 32'hB000_0000, 1'b0);
        chk("sf_hold_b0", 64'(m_valid[1]), 64'(0));
        send(1, 32'hB000_0001, 1'b0);
        chk("sf_hold_b1", 64'(m_valid[1]), 64'(0));
        send(1, 32'hB000_0002, 1'b1);
        chk("sf_release_valid", 64'(m_valid[1]), 64'(1));
        chk("sf_release_data", 64'(m_data[1]), 64'(32'hB000_0000));
        chk("sf_pkt_count1", 64'(pkt_count[1]), 64'(1));
        m_ready[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("sf_pop_pkt_count", 64'(pkt_count[1]), 64'((k < 2) ? 1 : 0));
        end
        m_ready[1] = 1'b0;
        chk("sf_drained_valid", 64'(m_valid[1]), 64'(0));

        // Simultaneous push(last) and pop(last) with two packets stored.
        send(1, 32'hC000_0000, 1'b1);
        send(1, 32'hC000_0001, 1'b1);
        chk("simul_pre_pkt", 64'(pkt_count[1]), 64'(2));
        s_valid[1] = 1'b1; s_data = 32'hC000_0002; s_last = 1'b1; m_ready[1] = 1'b1;
        step();
        s_valid[1] = 1'b0; m_ready[1] = 1'b0;
        chk("simul_pkt_count", 64'(pkt_count[1]), 64'(2));
        chk("simul_level", 64'(level[1]), 64'(2));
        chk("simul_m_data", 64'(m_data[1]), 64'(32'hC000_0001));
        drain(1);

        // Oversize: 6-beat packet through a 4-entry FIFO with the sink always ready.
        saw_full[1] = 1'b0;
        saw_ovs     = 1'b0;
        p0          = pops[1];
        m_ready[1]  = 1'b1;
        for (int k = 0; k < 6; k++) send(1, 32'hD000_0000 + k, (k == 5));
        drain(1);
        chk("ovs_full_seen", 64'(saw_full[1]), 64'(1));
        chk("ovs_set_seen", 64'(saw_ovs), 64'(1));
        chk("ovs_cleared", 64'(u_sf.oversize), 64'(0));
        chk("ovs_beats_out", 64'(pops[1] - p0), 64'(6));
        chk("ovs_pkt_count", 64'(pkt_count[1]), 64'(0));

        // Reset pulse mid-packet drops the partial packet.
        send(1, 32'hE000_0000, 1'b0);
        send(1, 32'hE000_0001, 1'b0);
        chk("midrst_pre_level", 64'(level[1]), 64'(2));
        rstn = 1'b0;
        step();
        chk("midrst_level", 64'(level[1]), 64'(0));
        chk("midrst_m_valid", 64'(m_valid[1]), 64'(0));
        chk("midrst_pkt_count", 64'(pkt_count[1]), 64'(0));
        chk("midrst_s_ready", 64'(s_ready[1]), 64'(1));
        rstn = 1'b1;
        step();
        chk("midrst_after_level", 64'(level[1]), 64'(0));

        // Random valid/ready traffic against the scoreboard.
        rand_run(0, 5000);
        rand_run(1, 5000);
        step();
        chk("sb_empty_cut", 64'(sb_q[0].size()), 64'(0));
        chk("sb_empty_sf", 64'(sb_q[1].size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
